dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory.
  - Port 0: the CPU load/store path.
  - Port 1: debug/loader path.
- One request is granted per cycle. The arbiter drives the memory's read/write/address/data inputs.
- Read data is registered and returned to the winning port one cycle after grant.
- Arbitration policy: CPU has fixed priority, with a counter that prevents starving port 1.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 10, word address width (memory depth 2**ADDR_WIDTH)
STARVE_LIMIT, 4, consecutive lost conflicts after which port 1 is forced to win; legal range 1..15

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
p0_valid  input  1  port 0 request present
p0_ready  output  1  port 0 request granted this cycle
p0_write  input  1  1 = write, 0 = read
p0_addr  input  ADDR_WIDTH  port 0 word address
p0_wdata  input  DATA_WIDTH  port 0 write data
p0_rvalid  output  1  port 0 read data valid (1-cycle pulse)
p0_rdata  output  DATA_WIDTH  port 0 read data
p1_valid, p1_ready, p1_write, p1_addr, p1_wdata, p1_rvalid, p1_rdata  same as port 0, for port 1
mem_read  output  1  to memory read enable
mem_write  output  1  to memory write enable
mem_addr  output  ADDR_WIDTH  to memory address
mem_wdata  output  DATA_WIDTH  to memory write data
mem_rdata  input  DATA_WIDTH  from memory, combinational read data

Behaviour:
- Interface: one clock (clock); reset is synchronous, active-high (reset).
- Handshake:
  - A transfer occurs in any cycle where pX_valid && pX_ready.
  - The requester holds valid, write, addr and wdata stable until ready is seen.
  - Back-to-back requests are allowed on both ports.
- Grant (combinational from inputs and starve_cnt):
  - Only p0_valid high: grant p0.
  - Only p1_valid high: grant p1.
  - Both high: grant p1 if starve_cnt == STARVE_LIMIT, else grant p0.
  - Neither high: no grant.
  - At most one ready is high in any cycle.
- Memory drive:
  - mem_read = grant && !write; mem_write = grant && write (write of the granted port).
  - mem_addr and mem_wdata come from the granted port.
  - With no grant, mem_addr and mem_wdata are all zeros and mem_read = mem_write = 0.
- starve_cnt (4-bit register, reset value 0):
  - Increments by 1 when both ports are valid and p0 is granted.
  - Clears to 0 when p1 is granted or p1_valid is low.
  - Never exceeds STARVE_LIMIT.
- Read response:
  - Cycle N: read granted to port X. Rising edge ending N: pX_rdata <= mem_rdata.
  - Cycle N+1: pX_rvalid = 1 for exactly one cycle.
  - pX_rdata holds its value until the next read completes on that port.
- Writes:
  - Commit at the rising edge ending the grant cycle. No rvalid pulse.
  - A read of the same address granted in cycle N+1 returns the new data.
- Simultaneous events:
  - A port whose rvalid is high may be granted again in the same cycle.
  - Responses for both ports are never pending in the same cycle, because grants are exclusive.
- Reset values: p0_rvalid = p1_rvalid = 0; p0_rdata = p1_rdata = 0; starve_cnt = 0.
- While reset is high:
  - p0_ready = p1_ready = 0; mem_read = mem_write = 0.
  - mem_addr and mem_wdata are all zeros.
- Reset mid-operation: a read granted in the cycle reset rises produces no rvalid. Memory contents are untouched by reset.

Decomposition:
- Shared package: port index constants (PORT_CPU = 0, PORT_DBG = 1); default DATA_WIDTH and ADDR_WIDTH.
- One natural sub-module: dmem_arb_grant.
  - Combinational grant logic plus the starve_cnt register.
  - Outputs a one-hot grant vector.
  - The top level holds the muxes and response registers.

Test Plan:
- Reset held 3 cycles, both ports valid: readys, mem_read and mem_write stay 0. After reset: rvalid = 0, rdata = 0.
- p0 writes 0xDEADBEEF to addr 5, then reads addr 5 next cycle: p0_rvalid pulses the cycle after the read grant, with p0_rdata = 0xDEADBEEF.
- Both ports continuously request reads, STARVE_LIMIT = 4:
  - p0 granted 4 cycles, p1 in the 5th, repeating.
  - starve_cnt sequence is 1, 2, 3, 4, 0.
- p1 alone writes 0x12345678 to addr 1023 (wrap-edge address): p1_ready = 1 the same cycle, mem_write = 1, mem_addr = 0x3FF. No rvalid on either port.
- p0 read to addr 2 granted in the cycle reset asserts: no p0_rvalid afterward. p0_rdata = 0 after reset.
- p1 read of addr 7 (contents 0x0000AAAA) granted while p0 is idle: p1_rdata = 0x0000AAAA with p1_rvalid one cycle later. p0_rvalid stays 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared constants for the data-memory arbiter slice.
//   PORT_CPU / PORT_DBG : bit positions of each requester in the one-hot grant
//                         vector (and port numbering in general).
//   DEFAULT_DATA_WIDTH  : default memory word width.
//   DEFAULT_ADDR_WIDTH  : default word address width.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 10;

endpackage

// File: rtl/dmem_arb_grant.sv
// -----------------------------------------------------------------------------
// dmem_arb_grant
// Grant decision for the two-port data-memory arbiter plus the anti-starvation
// counter. The CPU port wins every conflict except when the debug port has
// already lost STARVE_LIMIT conflicts in a row.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   p0_valid     : CPU port request present
//   p1_valid     : debug port request present
//   grant        : one-hot grant vector, bit PORT_CPU / PORT_DBG (combinational)
// -----------------------------------------------------------------------------
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       p0_valid,
  input  logic       p1_valid,
  output logic [1:0] grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       conflict;

  assign conflict = p0_valid && p1_valid;

  // Nothing is granted while reset is high so the memory sees no access.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (conflict) begin
        if (starve_cnt_q == LIMIT) begin
          grant[PORT_DBG] = 1'b1;
        end else begin
          grant[PORT_CPU] = 1'b1;
        end
      end else if (p0_valid) begin
        grant[PORT_CPU] = 1'b1;
      end else if (p1_valid) begin
        grant[PORT_DBG] = 1'b1;
      end
    end
  end

  // Counts consecutive conflicts lost by the debug port. Any cycle that is not
  // a lost conflict (debug granted, or debug not asking) clears it. The
  // saturation guard is defensive: at LIMIT the debug port always wins.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (conflict && grant[PORT_CPU]) begin
      if (starve_cnt_q < LIMIT) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = LIMIT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter in front of a single-port data memory with a
// combinational read path. Port 0 is the CPU load/store path, port 1 the
// debug/loader path.
//
// Handshake: a request transfers in any cycle where pX_valid && pX_ready. The
// requester holds valid/write/addr/wdata stable until ready is seen; ready is
// combinational from the current valids, and at most one ready is high.
// Read data is captured at the edge ending the grant cycle and presented with
// a one-cycle pX_rvalid pulse in the following cycle; pX_rdata then holds until
// the next read on that port completes. Writes commit at the grant edge and
// produce no rvalid.
//
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   pX_valid/pX_ready     : request handshake for port X
//   pX_write/addr/wdata   : request payload for port X
//   pX_rvalid/pX_rdata    : read response for port X
//   mem_read/mem_write    : memory enables (zero with no grant)
//   mem_addr/mem_wdata    : memory address / write data (zero with no grant)
//   mem_rdata             : combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic [1:0] grant;

  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;

  dmem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clock    (clock),
    .reset    (reset),
    .p0_valid (p0_valid),
    .p1_valid (p1_valid),
    .grant    (grant)
  );

  assign p0_ready = grant[PORT_CPU];
  assign p1_ready = grant[PORT_DBG];

  // Memory request mux; an idle cycle drives all zeros.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant[PORT_CPU]) begin
      mem_read  = !p0_write;
      mem_write = p0_write;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (grant[PORT_DBG]) begin
      mem_read  = !p1_write;
      mem_write = p1_write;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Grant is already forced low during reset, so a read presented in the
  // cycle reset rises never produces a response.
  always_comb begin
    p0_rvalid_d = grant[PORT_CPU] && !p0_write;
    p1_rvalid_d = grant[PORT_DBG] && !p1_write;
    p0_rdata_d  = p0_rvalid_d ? mem_rdata : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed-vector bench for dmem_arbiter with a behavioural single-port memory.
// The driver pushes the expected grant (cycle stamp, port, memory drive) and
// the expected read response (cycle stamp, data) into queues; a negedge
// monitor pops and compares whenever the DUT shows a ready or an rvalid.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int GW = 16 + 1 + 1 + 1 + AW + DW;  // cyc, port, rd, wr, addr, wdata
  localparam int RW = 16 + DW;                   // cyc, rdata
  localparam int NONE = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [15:0] cyc = 16'd0;
  always @(posedge clock) cyc <= cyc + 16'd1;

  // ---------------- DUT signals ----------------
  logic          p0_valid = 1'b0, p0_write = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_valid = 1'b0, p1_write = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .p0_valid  (p0_valid),
    .p0_ready  (p0_ready),
    .p0_write  (p0_write),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_valid  (p1_valid),
    .p1_ready  (p1_ready),
    .p1_write  (p1_write),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // ---------------- behavioural memory ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[2] = 32'h2222_2222;
    mem[7] = 32'h0000_AAAA;
  end
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_write) mem[mem_addr] <= mem_wdata;

  // ---------------- scoreboard ----------------
  logic [GW-1:0] exp_q[$];
  logic [RW-1:0] rsp0_q[$];
  logic [RW-1:0] rsp1_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [GW-1:0] eg, ag;
    logic [RW-1:0] er;
    check("ready_exclusive", 64'(p0_ready && p1_ready), 64'd0);
    if (p0_ready || p1_ready) begin
      ag = {cyc, p1_ready, mem_read, mem_write, mem_addr, mem_wdata};
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 64'(ag), 64'd0);
      end else begin
        eg = exp_q.pop_front();
        check("grant", 64'(ag), 64'(eg));
      end
    end else begin
      check("idle_mem_drive", 64'({mem_read, mem_write, mem_addr, mem_wdata}), 64'd0);
    end
    if (p0_rvalid) begin
      if (rsp0_q.size() == 0) check("unexpected_p0_rvalid", 64'({cyc, p0_rdata}), 64'd0);
      else begin
        er = rsp0_q.pop_front();
        check("p0_response", 64'({cyc, p0_rdata}), 64'(er));
      end
    end
    if (p1_rvalid) begin
      if (rsp1_q.size() == 0) check("unexpected_p1_rvalid", 64'({cyc, p1_rdata}), 64'd0);
      else begin
        er = rsp1_q.pop_front();
        check("p1_response", 64'({cyc, p1_rdata}), 64'(er));
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle of stimulus. exp_port: 0, 1 or NONE. exp_rd: read data expected
  // one cycle later for a granted read. exp_starve < 0 skips the counter check.
  task automatic step(input logic r,
                      input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input int exp_port, input logic [DW-1:0] exp_rd, input int exp_starve);
    reset = r;
    p0_valid = v0; p0_write = w0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_write = w1; p1_addr = a1; p1_wdata = d1;
    if (exp_port == 0) begin
      exp_q.push_back({cyc, 1'b0, !w0, w0, a0, d0});
      if (!w0) rsp0_q.push_back({cyc + 16'd1, exp_rd});
    end else if (exp_port == 1) begin
      exp_q.push_back({cyc, 1'b1, !w1, w1, a1, d1});
      if (!w1) rsp1_q.push_back({cyc + 16'd1, exp_rd});
    end
    @(posedge clock);
    #1;
    if (exp_starve >= 0) check("starve_cnt", 64'(dut.u_grant.starve_cnt_q), 64'(exp_starve));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, NONE, '0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held 3 cycles with both ports requesting: nothing may be granted.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 10'd7, '0, NONE, '0, 0);
    check("rst_p0_rvalid", 64'(p0_rvalid), 64'd0);
    check("rst_p1_rvalid", 64'(p1_rvalid), 64'd0);
    check("rst_p0_rdata", 64'(p0_rdata), 64'd0);
    check("rst_p1_rdata", 64'(p1_rdata), 64'd0);
    idle();

    // p0 write then read-back of the same address.
    step(1'b0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0, 0, '0, 0);
    step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b0, '0, '0, 0, 32'hDEAD_BEEF, 0);
    idle();

    // Continuous conflict: p0 wins 4, p1 wins the 5th, twice over.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= 4; k++)
        step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 10'd7, '0, 0, 32'hDEAD_BEEF, k);
      step(1'b0, 1'b1, 1'b0, 10'd5, '0, 1'b1, 1'b0, 10'd7, '0, 1, 32'h0000_AAAA, 0);
    end
    idle();

    // p1 alone writes the top address, then reads addr 7 and the top address.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h3FF, 32'h1234_5678, 1, '0, 0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd7, '0, 1, 32'h0000_AAAA, 0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h3FF, '0, 1, 32'h1234_5678, 0);
    idle();
    check("p0_rdata_hold", 64'(p0_rdata), 64'hDEAD_BEEF);

    // p0 write losing to a starved p1 is not modelled here; mixed write/read
    // conflict: p0 write wins, p1 read waits one cycle.
    step(1'b0, 1'b1, 1'b1, 10'd9, 32'h0000_0099, 1'b1, 1'b0, 10'd9, '0, 0, '0, 1);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd9, '0, 1, 32'h0000_0099, 0);
    idle();

    // Read presented in the cycle reset rises: no grant, no response.
    step(1'b1, 1'b1, 1'b0, 10'd2, '0, 1'b0, 1'b0, '0, '0, NONE, '0, 0);
    check("midrst_p0_rvalid", 64'(p0_rvalid), 64'd0);
    check("midrst_p0_rdata", 64'(p0_rdata), 64'd0);
    idle();
    check("post_rst_p0_rvalid", 64'(p0_rvalid), 64'd0);

    // Recovery: same read after reset succeeds.
    step(1'b0, 1'b1, 1'b0, 10'd2, '0, 1'b0, 1'b0, '0, '0, 0, 32'h2222_2222, 0);
    idle();
    idle();

    check("grant_queue_empty", 64'(exp_q.size()), 64'd0);
    check("p0_rsp_queue_empty", 64'(rsp0_q.size()), 64'd0);
    check("p1_rsp_queue_empty", 64'(rsp1_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
